// File: rtl/shifter_pkg.sv
// Shared types for the shifter-operand pipeline: op codes,
// shift-type enum and the decoded stage-1 bundle.
package shifter_pkg;

    localparam logic [2:0] OP_SHIFT  = 3'b000;
    localparam logic [2:0] OP_IMM32  = 3'b001;
    localparam logic [2:0] OP_LS_IMM = 3'b010;
    localparam logic [2:0] OP_LS_REG = 3'b011;

    typedef enum logic [1:0] {
        LSL = 2'b00,
        LSR = 2'b01,
        ASR = 2'b10,
        ROR = 2'b11
    } shift_t;

    // Decoded S1 fields; amounts are 9-bit so WIDTH and above stay distinct
    typedef struct packed {
        shift_t     typ;
        logic [8:0] amt;
        logic       rrx;
        logic       amt_zero;
        logic       amt_eq_w;
        logic       amt_ge_w;
        logic       illegal;
    } s1_t;

endpackage

// File: rtl/shifter_core.sv
// Combinational log2(WIDTH)-level barrel shifter with ARM carry-out.
// Ports: typ/amt/special flags, rm, cin in; result, carry out.
module shifter_core
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  shift_t             typ,
    input  logic [8:0]         amt,
    input  logic               rrx,
    input  logic               amt_zero,
    input  logic               amt_eq_w,
    input  logic               amt_ge_w,
    input  logic [WIDTH-1:0]   rm,
    input  logic               cin,
    output logic [WIDTH-1:0]   result,
    output logic               carry
);

    localparam int LG = $clog2(WIDTH);

    logic [LG-1:0]    r;
    logic [LG-1:0]    idx_r;
    logic [LG-1:0]    idx_l;
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] v;
    logic [WIDTH-1:0] lsl_res;
    logic             fill;

    assign r     = amt[LG-1:0];
    assign idx_r = r - LG'(1);
    // Left shift by r exposes bit WIDTH-r, i.e. -r modulo WIDTH
    assign idx_l = ~r + LG'(1);
    assign fill  = (typ == ASR) && rm[WIDTH-1];

    // Left shifts reuse the right-shift barrel on bit-reversed data
    always_comb begin
        src = '0;
        for (int i = 0; i < WIDTH; i++) begin
            src[i] = (typ == LSL) ? rm[WIDTH-1-i] : rm[i];
        end
        v = src;
        for (int i = 0; i < LG; i++) begin
            if (r[i]) begin
                if (typ == ROR) begin
                    v = (v >> (1 << i)) | (v << (WIDTH - (1 << i)));
                end else begin
                    v = (v >> (1 << i)) |
                        (fill ? ~({WIDTH{1'b1}} >> (1 << i)) : '0);
                end
            end
        end
        lsl_res = '0;
        for (int i = 0; i < WIDTH; i++) begin
            lsl_res[i] = v[WIDTH-1-i];
        end
    end

    always_comb begin
        result = rm;
        carry  = cin;
        if (rrx) begin
            result = {cin, rm[WIDTH-1:1]};
            carry  = rm[0];
        end else if (!amt_zero) begin
            case (typ)
                LSL: begin
                    result = amt_ge_w ? '0 : lsl_res;
                    carry  = amt_ge_w ? (amt_eq_w & rm[0]) : rm[idx_l];
                end
                LSR: begin
                    result = amt_ge_w ? '0 : v;
                    carry  = amt_ge_w ? (amt_eq_w & rm[WIDTH-1])
                                      : rm[idx_r];
                end
                ASR: begin
                    result = amt_ge_w ? {WIDTH{rm[WIDTH-1]}} : v;
                    carry  = amt_ge_w ? rm[WIDTH-1] : rm[idx_r];
                end
                default: begin
                    // Non-zero multiple of WIDTH leaves Rm in place
                    result = (r == '0) ? rm : v;
                    carry  = (r == '0) ? rm[WIDTH-1] : rm[idx_r];
                end
            endcase
        end
    end

endmodule

// File: rtl/shifter_operand_pipe.sv
// Two-stage valid/ready shifter-operand / load-store offset generator.
// Ports: clk, reset, in_* request (instr, rm, rs, cin, tag), out_* result.
module shifter_operand_pipe
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [WIDTH-1:0]  in_rm,
    input  logic [WIDTH-1:0]  in_rs,
    input  logic              in_cin,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_result,
    output logic              out_carry,
    output logic              out_illegal,
    output logic [TAG_W-1:0]  out_tag
);

    localparam logic [8:0] W9 = 9'(WIDTH);

    s1_t              dec;
    logic [WIDTH-1:0] rm_dec;
    logic [2:0]       op;
    logic [4:0]       imm5;

    logic             s1_valid_d, s1_valid_q;
    s1_t              s1_dec_d, s1_dec_q;
    logic [WIDTH-1:0] s1_rm_d, s1_rm_q;
    logic             s1_cin_d, s1_cin_q;
    logic [TAG_W-1:0] s1_tag_d, s1_tag_q;

    logic             s2_valid_d, s2_valid_q;
    logic [WIDTH-1:0] res_d, res_q;
    logic             carry_d, carry_q;
    logic             illegal_d, illegal_q;
    logic [TAG_W-1:0] tag_d, tag_q;

    logic [WIDTH-1:0] core_res;
    logic             core_carry;
    logic             s1_adv, s2_adv;

    assign op   = in_instr[27:25];
    assign imm5 = in_instr[11:7];

    // Every op is folded onto the barrel: immediates become Rm with
    // amount 0 (LSL) or a ROR by 2*rot.
    always_comb begin
        dec     = '0;
        dec.typ = shift_t'(in_instr[6:5]);
        rm_dec  = in_rm;
        unique case (1'b1)
            op[2]: begin
                dec.illegal = 1'b1;
            end
            op == OP_IMM32: begin
                dec.typ = ROR;
                dec.amt = {4'b0, in_instr[11:8], 1'b0};
                rm_dec  = WIDTH'(in_instr[7:0]);
            end
            op == OP_LS_IMM: begin
                dec.typ = LSL;
                rm_dec  = WIDTH'(in_instr[11:0]);
            end
            op == OP_SHIFT && in_instr[4]: begin
                dec.amt = {1'b0, in_rs[7:0]};
            end
            default: begin
                dec.amt = {4'b0, imm5};
                if (imm5 == '0) begin
                    case (dec.typ)
                        LSR, ASR: dec.amt = W9;
                        ROR:      dec.rrx = 1'b1;
                        default:  ;
                    endcase
                end
            end
        endcase
        dec.amt_zero = (dec.amt == '0);
        dec.amt_eq_w = (dec.amt == W9);
        dec.amt_ge_w = (dec.amt >= W9);
    end

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    shifter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .typ      (s1_dec_q.typ),
        .amt      (s1_dec_q.amt),
        .rrx      (s1_dec_q.rrx),
        .amt_zero (s1_dec_q.amt_zero),
        .amt_eq_w (s1_dec_q.amt_eq_w),
        .amt_ge_w (s1_dec_q.amt_ge_w),
        .rm       (s1_rm_q),
        .cin      (s1_cin_q),
        .result   (core_res),
        .carry    (core_carry)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_dec_d   = s1_dec_q;
        s1_rm_d    = s1_rm_q;
        s1_cin_d   = s1_cin_q;
        s1_tag_d   = s1_tag_q;
        s2_valid_d = s2_valid_q;
        res_d      = res_q;
        carry_d    = carry_q;
        illegal_d  = illegal_q;
        tag_d      = tag_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_dec_d = dec;
                s1_rm_d  = rm_dec;
                s1_cin_d = in_cin;
                s1_tag_d = in_tag;
            end
        end
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                res_d     = core_res;
                carry_d   = core_carry;
                illegal_d = s1_dec_q.illegal;
                tag_d     = s1_tag_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_dec_q   <= '0;
            s1_rm_q    <= '0;
            s1_cin_q   <= 1'b0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            carry_q    <= 1'b0;
            illegal_q  <= 1'b0;
            tag_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_dec_q   <= s1_dec_d;
            s1_rm_q    <= s1_rm_d;
            s1_cin_q   <= s1_cin_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            res_q      <= res_d;
            carry_q    <= carry_d;
            illegal_q  <= illegal_d;
            tag_q      <= tag_d;
        end
    end

    assign out_valid   = s2_valid_q;
    assign out_result  = res_q;
    assign out_carry   = carry_q;
    assign out_illegal = illegal_q;
    assign out_tag     = tag_q;

endmodule

// File: tb/tb_shifter_operand_pipe.sv
// Directed self-checking bench for shifter_operand_pipe (WIDTH=32).
// Inputs driven and outputs sampled on the falling clock edge.
module tb_shifter_operand_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_rm;
    logic [31:0] in_rs;
    logic        in_cin;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_carry;
    logic        out_illegal;
    logic [3:0]  out_tag;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] held;

    always #5 clk = ~clk;

    shifter_operand_pipe #(
        .WIDTH (32),
        .TAG_W (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_rm       (in_rm),
        .in_rs       (in_rs),
        .in_cin      (in_cin),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_carry   (out_carry),
        .out_illegal (out_illegal),
        .out_tag     (out_tag)
    );

    task automatic chk(input string nm, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", nm, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] rm,
                         input logic [31:0] rs, input logic cin,
                         input logic [3:0] tag);
        in_valid = 1'b1;
        in_instr = instr;
        in_rm    = rm;
        in_rs    = rs;
        in_cin   = cin;
        in_tag   = tag;
    endtask

    // Single request through an empty pipe: accept, 2-edge latency, drain
    task automatic run_one(input string nm, input logic [31:0] instr,
                           input logic [31:0] rm, input logic [31:0] rs,
                           input logic cin, input logic [3:0] tag,
                           input logic [31:0] er, input logic ec,
                           input logic ei);
        out_ready = 1'b1;
        drive(instr, rm, rs, cin, tag);
        #1;
        chk({nm, ".in_ready"}, 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0;
        #1;
        chk({nm, ".early"}, 32'(out_valid), 32'd0);
        cyc();
        chk({nm, ".valid"}, 32'(out_valid), 32'd1);
        chk({nm, ".result"}, out_result, er);
        chk({nm, ".carry"}, 32'(out_carry), 32'(ec));
        chk({nm, ".illegal"}, 32'(out_illegal), 32'(ei));
        chk({nm, ".tag"}, 32'(out_tag), 32'(tag));
        cyc();
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_rm     = '0;
        in_rs     = '0;
        in_cin    = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.result", out_result, 32'd0);
        chk("rst.tag", 32'(out_tag), 32'd0);

        run_one("lsl4", 32'h0000_0200, 32'h1000_000F, 0, 1'b0, 4'd1,
                32'h0000_00F0, 1'b1, 1'b0);
        run_one("rrx", 32'h0000_0060, 32'h0000_0003, 0, 1'b1, 4'd2,
                32'h8000_0001, 1'b1, 1'b0);
        run_one("lsr0", 32'h0000_0020, 32'h8000_0001, 0, 1'b0, 4'd3,
                32'h0000_0000, 1'b1, 1'b0);
        run_one("ror8", 32'h0000_0460, 32'h0000_00AB, 0, 1'b0, 4'd4,
                32'hAB00_0000, 1'b1, 1'b0);
        run_one("ls_asr0", 32'h0600_0040, 32'h7FFF_FFFF, 0, 1'b1, 4'd5,
                32'h0000_0000, 1'b0, 1'b0);
        run_one("rlsl4", 32'h0000_0010, 32'h1000_000F, 32'h4, 1'b0, 4'd6,
                32'h0000_00F0, 1'b1, 1'b0);
        run_one("rlsl32", 32'h0000_0010, 32'h0000_0001, 32'h20, 1'b0, 4'd7,
                32'h0000_0000, 1'b1, 1'b0);
        run_one("rlsl33", 32'h0000_0010, 32'h0000_0001, 32'h21, 1'b1, 4'd8,
                32'h0000_0000, 1'b0, 1'b0);
        run_one("rlsr4", 32'h0000_0030, 32'h0000_00F0, 32'h4, 1'b1, 4'd9,
                32'h0000_000F, 1'b0, 1'b0);
        run_one("rasr40", 32'h0000_0050, 32'h8000_0000, 32'h28, 1'b0, 4'd10,
                32'hFFFF_FFFF, 1'b1, 1'b0);
        run_one("rasr0", 32'h0000_0050, 32'h8000_0000, 32'h100, 1'b0, 4'd11,
                32'h8000_0000, 1'b0, 1'b0);
        run_one("rror64", 32'h0000_0070, 32'h8000_0000, 32'h40, 1'b0, 4'd12,
                32'h8000_0000, 1'b1, 1'b0);
        run_one("imm_rot4", 32'h0200_04FF, 32'h0, 0, 1'b0, 4'd13,
                32'hFF00_0000, 1'b1, 1'b0);
        run_one("imm_rot0", 32'h0200_00FF, 32'h0, 0, 1'b1, 4'd14,
                32'h0000_00FF, 1'b1, 1'b0);
        run_one("ls_imm", 32'h0400_0ABC, 32'h5555_5555, 0, 1'b1, 4'd15,
                32'h0000_0ABC, 1'b1, 1'b0);
        run_one("illegal", 32'h0800_0000, 32'h1234_5678, 0, 1'b1, 4'd0,
                32'h1234_5678, 1'b1, 1'b1);

        // Backpressure: out_ready low while tags 1..4 are offered
        out_ready = 1'b0;
        drive(32'h0, 32'hA1, 0, 1'b0, 4'd1);
        #1;
        chk("bp.acc1", 32'(in_ready), 32'd1);
        cyc();
        drive(32'h0, 32'hA2, 0, 1'b0, 4'd2);
        #1;
        chk("bp.acc2", 32'(in_ready), 32'd1);
        cyc();
        drive(32'h0, 32'hA3, 0, 1'b0, 4'd3);
        held = out_result;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp.stall_ready", 32'(in_ready), 32'd0);
            chk("bp.head_valid", 32'(out_valid), 32'd1);
            chk("bp.head_tag", 32'(out_tag), 32'd1);
            chk("bp.head_result", out_result, 32'hA1);
            chk("bp.head_stable", out_result, held);
            cyc();
        end
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            logic acc;
            #1;
            chk("bp.drain_valid", 32'(out_valid), 32'd1);
            chk("bp.drain_tag", 32'(out_tag), 32'(k));
            chk("bp.drain_result", out_result, 32'hA0 + 32'(k));
            acc = in_valid && in_ready;
            cyc();
            if (acc) begin
                if (in_tag == 4'd3) begin
                    drive(32'h0, 32'hA4, 0, 1'b0, 4'd4);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        #1;
        chk("bp.empty", 32'(out_valid), 32'd0);
        chk("bp.all_sent", 32'(in_valid), 32'd0);

        // Reset with both stages full
        out_ready = 1'b0;
        drive(32'h0, 32'hB5, 0, 1'b1, 4'd5);
        cyc();
        drive(32'h0, 32'hB6, 0, 1'b1, 4'd6);
        cyc();
        in_valid = 1'b0;
        #1;
        chk("rst2.full_ready", 32'(in_ready), 32'd0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        chk("rst2.out_valid", 32'(out_valid), 32'd0);
        chk("rst2.in_ready", 32'(in_ready), 32'd1);
        chk("rst2.result", out_result, 32'd0);
        chk("rst2.carry", 32'(out_carry), 32'd0);
        chk("rst2.tag", 32'(out_tag), 32'd0);
        run_one("post_rst", 32'h0000_0200, 32'h0000_0001, 0, 1'b0, 4'd9,
                32'h0000_0010, 1'b0, 1'b0);
        #1;
        chk("post_rst.no_stale", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
